// File: rtl/fixed_act_pkg.sv
// rtl/fixed_act_pkg.sv - shared types and width helpers for the fixed-point activation pipe
package fixed_act_pkg;

    typedef enum logic [1:0] {
        ACT_RELU   = 2'd0,
        ACT_LEAKY  = 2'd1,
        ACT_RELU6  = 2'd2,
        ACT_BYPASS = 2'd3
    } act_mode_t;

    // Stage-1 product width: input times slope plus one guard bit.
    function automatic int prod_width(input int in_w, input int alpha_w);
        return in_w + alpha_w + 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fixed_act_lane.sv
// rtl/fixed_act_lane.sv - per-lane activation transform followed by round-half-up requantise/saturate
module fixed_act_lane
    import fixed_act_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int IN_F        = 3,
    parameter int OUT_W       = 8,
    parameter int OUT_F       = 3,
    parameter int ALPHA_W     = 8,
    parameter int ALPHA_F     = 7,
    parameter int LEAKY_ALPHA = 13
) (
    input  logic signed [IN_W-1:0]  x,
    input  act_mode_t               mode,
    output logic        [OUT_W-1:0] y,
    output logic                    clipped
);

    localparam int P_W   = prod_width(IN_W, ALPHA_W);
    localparam int IF_W  = IN_F + ALPHA_F;
    localparam int SHIFT = IF_W - OUT_F;
    localparam int RSH   = (SHIFT > 0) ? SHIFT : 0;
    localparam int LSH   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int EXT_W = max_int(P_W + LSH, OUT_W) + 2;

    localparam logic signed [ALPHA_W-1:0] ALPHA  = ALPHA_W'(LEAKY_ALPHA);
    localparam logic signed [P_W-1:0]     SIX_IN = P_W'(6 << IN_F);
    localparam logic signed [P_W-1:0]     SIX_P  = P_W'(6 << IF_W);
    localparam logic signed [EXT_W-1:0]   RND    =
        (RSH > 0) ? (EXT_W'(1) <<< ((RSH > 0) ? RSH - 1 : 0)) : '0;
    localparam logic signed [EXT_W-1:0]   MAX_E  = EXT_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0]   MIN_E  = ~MAX_E;

    logic signed [P_W-1:0]           x_ext;
    logic signed [P_W-1:0]           scaled;
    logic signed [IN_W+ALPHA_W-1:0]  prod;
    logic signed [P_W-1:0]           leak;
    logic signed [P_W-1:0]           p;
    logic signed [EXT_W-1:0]         wide;
    logic signed [EXT_W-1:0]         rounded;

    assign x_ext  = {{(P_W-IN_W){x[IN_W-1]}}, x};
    assign scaled = x_ext <<< ALPHA_F;
    assign prod   = x * ALPHA;
    assign leak   = {{(P_W-IN_W-ALPHA_W){prod[IN_W+ALPHA_W-1]}}, prod};

    // Every mode lands on the common IN_F+ALPHA_F fraction so stage 2 is mode-agnostic.
    always_comb begin
        p = scaled;
        case (mode)
            ACT_RELU:   p = (x_ext > 0) ? scaled : '0;
            ACT_LEAKY:  p = (x_ext < 0) ? leak : scaled;
            ACT_RELU6: begin
                if (x_ext <= 0)
                    p = '0;
                else if (x_ext > SIX_IN)
                    p = SIX_P;
                else
                    p = scaled;
            end
            ACT_BYPASS: p = scaled;
            default:    p = scaled;
        endcase
    end

    assign wide    = {{(EXT_W-P_W){p[P_W-1]}}, p};
    assign rounded = ((wide <<< LSH) + RND) >>> RSH;

    always_comb begin
        clipped = 1'b1;
        y       = rounded[OUT_W-1:0];
        if (rounded > MAX_E) begin
            y = MAX_E[OUT_W-1:0];
        end else if (rounded < MIN_E) begin
            y = MIN_E[OUT_W-1:0];
        end else begin
            clipped = 1'b0;
        end
    end

endmodule

// File: rtl/fixed_relu_pipe.sv
// rtl/fixed_relu_pipe.sv - two-stage valid/ready ReLU-family activation with requantisation
module fixed_relu_pipe
    import fixed_act_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 3,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 3,
    parameter int LEAKY_ALPHA                 = 13,
    parameter int ALPHA_W                     = 8,
    parameter int ALPHA_F                     = 7
) (
    input  logic                                                        clk,
    input  logic                                                        rst,
    input  logic [1:0]                                                  mode,
    input  logic [DATA_IN_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]   data_in_0,
    input  logic                                                        data_in_0_valid,
    output logic                                                        data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]  data_out_0,
    output logic                                                        data_out_0_valid,
    input  logic                                                        data_out_0_ready,
    output logic                                                        sat_flag
);

    localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int IN_W  = DATA_IN_0_PRECISION_0;
    localparam int OUT_W = DATA_OUT_0_PRECISION_0;

    logic                 v1;
    logic [IN_W*N-1:0]    s1_data;
    act_mode_t            s1_mode;
    logic                 s1_load;
    logic                 s2_load;
    logic [OUT_W*N-1:0]   lane_y;
    logic [N-1:0]         lane_clip;

    assign s2_load         = !data_out_0_valid || data_out_0_ready;
    assign s1_load         = !v1 || s2_load;
    assign data_in_0_ready = s1_load;

    for (genvar i = 0; i < N; i++) begin : g_lane
        fixed_act_lane #(
            .IN_W        (IN_W),
            .IN_F        (DATA_IN_0_PRECISION_1),
            .OUT_W       (OUT_W),
            .OUT_F       (DATA_OUT_0_PRECISION_1),
            .ALPHA_W     (ALPHA_W),
            .ALPHA_F     (ALPHA_F),
            .LEAKY_ALPHA (LEAKY_ALPHA)
        ) u_lane (
            .x       (s1_data[i*IN_W +: IN_W]),
            .mode    (s1_mode),
            .y       (lane_y[i*OUT_W +: OUT_W]),
            .clipped (lane_clip[i])
        );
    end

    // Stage 1 captures the raw beat and its mode; the lane math sits between S1 and S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1               <= 1'b0;
            s1_data          <= '0;
            s1_mode          <= ACT_RELU;
            data_out_0_valid <= 1'b0;
            data_out_0       <= '0;
            sat_flag         <= 1'b0;
        end else begin
            if (s1_load) begin
                v1 <= data_in_0_valid;
                if (data_in_0_valid) begin
                    s1_data <= data_in_0;
                    s1_mode <= act_mode_t'(mode);
                end
            end
            if (s2_load) begin
                data_out_0_valid <= v1;
                if (v1) begin
                    data_out_0 <= lane_y;
                    sat_flag   <= sat_flag | (|lane_clip);
                end
            end
        end
    end

endmodule

// File: tb/tb_fixed_relu_pipe.sv
// tb/tb_fixed_relu_pipe.sv - directed self-checking bench for fixed_relu_pipe
module tb_fixed_relu_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        sat;

    logic [1:0]  b_mode = 2'd0;
    logic [31:0] b_din = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [31:0] b_dout;
    logic        b_dout_valid;
    logic        b_dout_ready = 1'b1;
    logic        b_sat;

    int checks = 0;
    int failures = 0;
    logic        mon_en = 1'b0;
    logic [31:0] out_q[$];

    always #5 clk = ~clk;

    fixed_relu_pipe u_dut (
        .clk              (clk),
        .rst              (rst),
        .mode             (mode),
        .data_in_0        (din),
        .data_in_0_valid  (din_valid),
        .data_in_0_ready  (din_ready),
        .data_out_0       (dout),
        .data_out_0_valid (dout_valid),
        .data_out_0_ready (dout_ready),
        .sat_flag         (sat)
    );

    fixed_relu_pipe #(.DATA_OUT_0_PRECISION_1(5)) u_dut_f5 (
        .clk              (clk),
        .rst              (rst),
        .mode             (b_mode),
        .data_in_0        (b_din),
        .data_in_0_valid  (b_valid),
        .data_in_0_ready  (b_ready),
        .data_out_0       (b_dout),
        .data_out_0_valid (b_dout_valid),
        .data_out_0_ready (b_dout_ready),
        .sat_flag         (b_sat)
    );

    always @(negedge clk) begin
        if (mon_en && !rst && dout_valid && dout_ready)
            out_q.push_back(dout);
    end

    function automatic logic [31:0] bp_in(input int k);
        logic [31:0] r;
        for (int i = 0; i < 3; i++)
            r[i*8 +: 8] = 8'(4*k + i + 1);
        r[31:24] = 8'(-(k + 1));
        return r;
    endfunction

    // Even beats use RELU (negative lane clamps to 0), odd beats BYPASS (passes through).
    function automatic logic [31:0] bp_exp(input int k);
        logic [31:0] r;
        r = bp_in(k);
        if (k % 2 == 0)
            r[31:24] = 8'd0;
        return r;
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic [1:0] m);
        int n;
        din       = d;
        mode      = m;
        din_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!din_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!din_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: din_ready=%b required=1", din_ready);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got=%b exp=0", dout_valid); end
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_data: got=%h exp=00000000", dout); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat: got=%b exp=0", sat); end
        checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got=%b exp=1", din_ready); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_relu();
        dout_ready = 1'b1;
        send_beat(32'h7F0500F8, 2'd0);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL relu_lat1: got=%b exp=0", dout_valid); end
        @(posedge clk);
        #1;
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL relu_lat2: got=%b exp=1", dout_valid); end
        checks++; if (dout !== 32'h7F050000) begin failures++; $display("FAIL relu_data: got=%h exp=7f050000", dout); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL relu_sat: got=%b exp=0", sat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_relu6();
        send_beat(32'hFD2F303C, 2'd2);
        @(posedge clk);
        #1;
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL relu6_valid: got=%b exp=1", dout_valid); end
        checks++; if (dout !== 32'h002F3030) begin failures++; $display("FAIL relu6_data: got=%h exp=002f3030", dout); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_leaky();
        send_beat(32'h00FF28B0, 2'd1);
        @(posedge clk);
        #1;
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL leaky_valid: got=%b exp=1", dout_valid); end
        checks++; if (dout !== 32'h000028F8) begin failures++; $display("FAIL leaky_data: got=%h exp=000028f8", dout); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL leaky_sat: got=%b exp=0", sat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bypass_sat_out85();
        b_din   = 32'h0003807F;
        b_mode  = 2'd3;
        b_valid = 1'b1;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (b_dout_valid !== 1'b1) begin failures++; $display("FAIL sat85_valid: got=%b exp=1", b_dout_valid); end
        checks++; if (b_dout !== 32'h000C807F) begin failures++; $display("FAIL sat85_data: got=%h exp=000c807f", b_dout); end
        checks++; if (b_sat !== 1'b1) begin failures++; $display("FAIL sat85_flag: got=%b exp=1", b_sat); end
        b_din   = 32'h0;
        b_mode  = 2'd0;
        b_valid = 1'b1;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (b_dout !== 32'h0) begin failures++; $display("FAIL sat85_zero: got=%h exp=00000000", b_dout); end
        checks++; if (b_sat !== 1'b1) begin failures++; $display("FAIL sat85_sticky: got=%b exp=1", b_sat); end
    endtask

    task automatic test_back_to_back();
        int n;
        out_q.delete();
        mon_en     = 1'b1;
        dout_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send_beat(bp_in(k), (k % 2 == 0) ? 2'd0 : 2'd3);
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got=%b exp=0", din_ready); end
                checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL bp_held_valid: got=%b exp=1", dout_valid); end
                checks++; if (dout !== bp_exp(0)) begin failures++; $display("FAIL bp_held_data: got=%h exp=%h", dout, bp_exp(0)); end
                dout_ready = 1'b1;
            end
        join
        n = 0;
        while (out_q.size() < 6 && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        checks++; if (out_q.size() != 6) begin failures++; $display("FAIL bp_count: got=%0d exp=6", out_q.size()); end
        for (int k = 0; k < 6; k++) begin
            if (k < out_q.size()) begin
                checks++;
                if (out_q[k] !== bp_exp(k)) begin
                    failures++;
                    $display("FAIL bp_beat%0d: got=%h exp=%h", k, out_q[k], bp_exp(k));
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        dout_ready = 1'b0;
        send_beat(32'h01020304, 2'd0);
        send_beat(32'h05060708, 2'd0);
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL rstf_pre_valid: got=%b exp=1", dout_valid); end
        rst       = 1'b1;
        din       = 32'h11111111;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL rstf_valid: got=%b exp=0", dout_valid); end
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL rstf_data: got=%h exp=00000000", dout); end
        checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL rstf_ready: got=%b exp=1", din_ready); end
        checks++; if (b_sat !== 1'b0) begin failures++; $display("FAIL rstf_sat: got=%b exp=0", b_sat); end
        rst        = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL rstf_drop: got=%b exp=0", dout_valid); end
    endtask

    initial begin
        test_reset();
        test_relu();
        test_relu6();
        test_leaky();
        test_bypass_sat_out85();
        test_back_to_back();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule
